// File: rtl/instr_fetch.sv
// Fetch stage of the multi-cycle RV32 core.
// Owns PC, next-PC and IR, and runs a single-outstanding req/gnt/rvalid
// handshake with instruction memory. The fetched word stays frozen until the
// controller pulses advance, which selects a sequential or PC-relative next PC.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        taken,
    input  logic [31:0] target_offset,
    output logic        fetch_err,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        StReset,
        StReq,
        StWait,
        StHold,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic [31:0] target;
    logic        misaligned;
    logic        latch_rsp;
    logic        accept_adv;

    assign target     = pc_q + target_offset;
    assign misaligned = taken && (target[1:0] != 2'b00);
    // Response is accepted in WAIT, or in REQ when it arrives with the grant.
    assign latch_rsp  = imem_rvalid &&
                        ((state_q == StWait) || ((state_q == StReq) && imem_gnt));
    assign accept_adv = (state_q == StHold) && advance;

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset: state_d = StReq;
            StReq: begin
                if (imem_gnt) begin
                    state_d = imem_rvalid ? StHold : StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (advance) begin
                    state_d = misaligned ? StErr : StReq;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StReset;
        endcase
    end

    // FSM-driven outputs.
    always_comb begin
        imem_req = (state_q == StReq);
    end

    // Datapath registers: npc, pc, IR, valid flag, sticky error, retire count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            npc_q         <= RESET_PC;
            pc_q          <= RESET_PC;
            ir_q          <= NOP_INSTR;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            npc_q         <= npc_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Datapath next-state: latch on response, update npc/count on advance.
    always_comb begin
        npc_d         = npc_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        valid_d       = valid_q;
        err_d         = err_q;
        instr_count_d = instr_count_q;
        if (latch_rsp) begin
            ir_d    = imem_rdata;
            pc_d    = npc_q;
            valid_d = 1'b1;
        end
        if (accept_adv) begin
            instr_count_d = instr_count_q + 32'd1;
            valid_d       = 1'b0;
            // A misaligned redirect leaves npc alone and parks the stage in ERR.
            if (misaligned) begin
                err_d = 1'b1;
            end else begin
                npc_d = taken ? target : (pc_q + 32'd4);
            end
        end
    end

    assign imem_addr   = npc_q;
    assign instruction = ir_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_err   = err_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        taken;
    logic [31:0] target_offset;
    logic        fetch_err;
    logic [31:0] instr_count;

    int n_checks;
    int n_errors;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .advance       (advance),
        .taken         (taken),
        .target_offset (target_offset),
        .fetch_err     (fetch_err),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a negedge while in HOLD; one-cycle advance pulse.
    task automatic advance_once(input logic tk, input logic [31:0] off);
        advance       = 1'b1;
        taken         = tk;
        target_offset = off;
        @(negedge clk);
        advance       = 1'b0;
        taken         = 1'b0;
        target_offset = 32'd0;
    endtask

    // Called at a negedge while in REQ; grants after gnt_dly cycles and
    // responds rv_dly cycles after the grant (0 = same cycle).
    task automatic serve(input int gnt_dly, input int rv_dly, input logic [31:0] data,
                         input logic [31:0] addr);
        for (int i = 0; i < gnt_dly; i++) begin
            check_eq("req_before_gnt", 32'(imem_req), 32'd1);
            check_eq("addr_stable", imem_addr, addr);
            check_eq("valid_low_req", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end
        check_eq("req_at_gnt", 32'(imem_req), 32'd1);
        check_eq("addr_at_gnt", imem_addr, addr);
        imem_gnt = 1'b1;
        if (rv_dly == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data;
        end
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (rv_dly > 0) begin
            for (int i = 0; i < rv_dly - 1; i++) begin
                check_eq("req_low_wait", 32'(imem_req), 32'd0);
                check_eq("valid_low_wait", 32'(instr_valid), 32'd0);
                @(negedge clk);
            end
            check_eq("valid_low_wait", 32'(instr_valid), 32'd0);
            imem_rvalid = 1'b1;
            imem_rdata  = data;
            @(negedge clk);
            imem_rvalid = 1'b0;
        end
        check_eq("valid_up", 32'(instr_valid), 32'd1);
        check_eq("ir", instruction, data);
        check_eq("pc", pc, addr);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        imem_gnt      = 1'b1;
        imem_rvalid   = 1'b1;
        imem_rdata    = 32'h0050_0093;
        advance       = 1'b0;
        taken         = 1'b0;
        target_offset = 32'd0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_ir", instruction, 32'h0000_0013);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_err", 32'(fetch_err), 32'd0);
        check_eq("rst_count", instr_count, 32'd0);

        // Release with gnt/rvalid tied high.
        rst = 1'b0;
        @(negedge clk);
        check_eq("first_req", 32'(imem_req), 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);
        check_eq("first_valid_low", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check_eq("first_ir", instruction, 32'h0050_0093);
        check_eq("first_pc", pc, 32'h0);
        check_eq("first_pc4", pc_plus4, 32'h4);
        check_eq("first_valid", 32'(instr_valid), 32'd1);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;

        // Sequential advances with delayed memory.
        advance_once(1'b0, 32'd0);
        serve(2, 3, 32'h0000_1111, 32'h4);
        advance_once(1'b0, 32'd0);
        serve(2, 3, 32'h0000_2222, 32'h8);
        advance_once(1'b0, 32'd0);
        serve(2, 3, 32'h0000_3333, 32'hC);
        check_eq("count3", instr_count, 32'd3);
        check_eq("pc4_c", pc_plus4, 32'h10);

        // Taken redirects.
        advance_once(1'b0, 32'd0);
        serve(0, 0, 32'h0000_4444, 32'h10);
        advance_once(1'b1, 32'hFFFF_FFF8);
        serve(1, 1, 32'h0000_5555, 32'h8);
        advance_once(1'b1, 32'h0000_0100);
        serve(0, 2, 32'h0000_6666, 32'h108);
        advance_once(1'b1, 32'hFFFF_FF00);
        serve(0, 0, 32'h0000_7777, 32'h8);
        check_eq("count7", instr_count, 32'd7);

        // Stray rvalid in HOLD.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check_eq("hold_rv_ir", instruction, 32'h0000_7777);
        check_eq("hold_rv_pc", pc, 32'h8);
        check_eq("hold_rv_count", instr_count, 32'd7);

        // Spurious advance in REQ and WAIT.
        advance_once(1'b0, 32'd0);
        advance       = 1'b1;
        taken         = 1'b1;
        target_offset = 32'h40;
        @(negedge clk);
        check_eq("req_adv_addr", imem_addr, 32'hC);
        check_eq("req_adv_req", 32'(imem_req), 32'd1);
        check_eq("req_adv_count", instr_count, 32'd8);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        check_eq("wait_req_low", 32'(imem_req), 32'd0);
        @(negedge clk);
        advance       = 1'b0;
        taken         = 1'b0;
        target_offset = 32'd0;
        check_eq("wait_adv_count", instr_count, 32'd8);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_8888;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check_eq("spur_ir", instruction, 32'h0000_8888);
        check_eq("spur_pc", pc, 32'hC);
        check_eq("spur_count", instr_count, 32'd8);

        // Retire-count wrap.
        force dut.instr_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instr_count_q;
        check_eq("count_forced", instr_count, 32'hFFFF_FFFF);
        advance_once(1'b1, 32'hFFFF_FFFC);
        check_eq("count_wrap", instr_count, 32'd0);
        serve(0, 1, 32'h0000_9999, 32'h8);

        // Misaligned redirect.
        imem_gnt = 1'b1;
        advance_once(1'b1, 32'h2);
        check_eq("err_flag", 32'(fetch_err), 32'd1);
        check_eq("err_count", instr_count, 32'd1);
        for (int i = 0; i < 20; i++) begin
            check_eq("err_req_low", 32'(imem_req), 32'd0);
            check_eq("err_valid_low", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end
        imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("err_rst_flag", 32'(fetch_err), 32'd0);
        check_eq("err_rst_count", instr_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_err_req", 32'(imem_req), 32'd1);
        check_eq("post_err_addr", imem_addr, 32'h0);
        serve(0, 0, 32'h0000_AAAA, 32'h0);

        // Reset while WAIT at 0x20, then stray rvalid in RESET_ST.
        advance_once(1'b1, 32'h20);
        check_eq("addr_20", imem_addr, 32'h20);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        check_eq("wait20_req_low", 32'(imem_req), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("midrst_ir", instruction, 32'h0000_0013);
        check_eq("midrst_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check_eq("stray_ir", instruction, 32'h0000_0013);
        check_eq("stray_valid", 32'(instr_valid), 32'd0);
        check_eq("stray_req", 32'(imem_req), 32'd1);
        check_eq("stray_addr", imem_addr, 32'h0);
        check_eq("stray_pc", pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the multi-cycle RV32 core, directly upstream of the instruction decoder.
- Owns the PC and instruction register (IR) and runs a single-outstanding request/grant/response handshake with instruction memory.
- Holds the fetched word stable to decode until the core controller advances it.
- On advance, applies the next-PC choice: sequential, or PC-relative using the offset produced by decode.

Parameters:
RESET_PC  32'h0000_0000  PC of first fetch after reset
NOP_INSTR  32'h0000_0013  IR contents while no valid instruction (addi x0,x0,0)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  instruction memory request, held until granted
imem_addr  output  32  word-aligned fetch address, stable while imem_req=1
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  response data valid this cycle
imem_rdata  input  32  fetched instruction
instruction  output  32  IR contents to decode
instr_valid  output  1  IR holds a valid, unconsumed instruction
pc  output  32  address of the instruction in IR
pc_plus4  output  32  pc + 4 (JAL/JALR link value)
advance  input  1  controller done with current instruction; fetch next
taken  input  1  qualifies advance: redirect instead of sequential
target_offset  input  32  signed byte offset from pc, used when taken=1
fetch_err  output  1  sticky misaligned-target error
instr_count  output  32  instructions retired (advance pulses accepted)

Behaviour:
- Reset (async, any state, including mid-handshake): state=RESET_ST, pc=RESET_PC, IR=NOP_INSTR, instr_valid=0, imem_req=0, fetch_err=0, instr_count=0. Any response for a request abandoned by reset is ignored.
- Next-PC register npc; reset value RESET_PC. imem_addr = npc.
- States:
  - RESET_ST: one cycle after reset release -> REQ.
  - REQ: imem_req=1. If imem_gnt=1 -> WAIT, or -> HOLD if imem_rvalid=1 in the same cycle (latch as below).
  - WAIT: imem_req=0. On imem_rvalid: IR<=imem_rdata, pc<=npc, instr_valid<=1 -> HOLD.
  - HOLD: instr_valid=1; IR and pc frozen. On advance:
    - instr_count += 1 (wraps 2^32-1 -> 0).
    - npc <= taken ? pc + target_offset : pc + 4 (32-bit modular add, no overflow flag).
    - instr_valid<=0 -> REQ.
  - ERR: imem_req=0, instr_valid=0, fetch_err=1. Exit only via rst.
- Misalignment: on advance with taken=1 and (pc+target_offset)[1:0]!=0, go to ERR instead of REQ. npc is not updated; instr_count still increments.
- imem_rvalid outside WAIT (and outside the REQ+gnt case) is ignored. imem_gnt outside REQ is ignored. advance outside HOLD is ignored; taken and target_offset are don't-care without advance.
- instr_valid is low from the advance edge until the new word is latched. The minimum fetch-to-fetch interval is 2 cycles (HOLD -> REQ with gnt+rvalid -> HOLD).
- pc_plus4 is combinational from the pc register.
- The npc/IR latch happens in the cycle rvalid is sampled. instruction changes exactly when instr_valid rises.
- Memory is never sent a second request before the first response returns.

Test Plan:
- Reset release with gnt=rvalid=1 tied high, rdata=32'h00500093 -> imem_req rises 1 cycle after release with addr 0; next cycle instruction=32'h00500093, pc=0, pc_plus4=4, instr_valid=1.
- In HOLD, advance taken=0 three times, with memory gnt delayed 2 cycles and rvalid 3 cycles after gnt -> addresses 4, 8, 12 issued; imem_addr stable while req high; instr_valid low during each wait; instr_count=3.
- At pc=32'h10, advance taken=1, target_offset=32'hFFFFFFF8 -> next imem_addr=32'h08. Then offset 32'h0000_0100 from pc=8 -> addr 32'h108.
- Advance taken=1, offset=32'h2 from pc=32'h8 -> fetch_err=1, imem_req stays 0 for 20 cycles, instr_valid=0. rst pulse clears to RESET_PC fetch.
- Assert rst while in WAIT at addr 32'h20, then drive stray rvalid with rdata=32'hDEADBEEF during RESET_ST -> IR remains 32'h00000013, instr_valid=0, first post-reset fetch address RESET_PC.
- Spurious advance in REQ/WAIT and rvalid in HOLD -> no change to pc, IR, instr_count; instr_count wrap tested by forcing to 32'hFFFFFFFF then one advance -> 0.
